// File: rtl/cpc_slot_sequencer.sv
// cpc_slot_sequencer: PERIOD-phase bus-slot frame with CPU wait, video strobe and round-robin DMA grants.
// Define SLOT_STATS_EN to build the saturating wait_count statistics counter.
module cpc_slot_sequencer #(
    parameter int PERIOD    = 4,
    parameter int CPU_PHASE = 0,
    parameter int VID_PHASE = 2,
    parameter int NUM_CH    = 2,
    localparam int PW       = (PERIOD > 2) ? $clog2(PERIOD) : 1,
    localparam int RW       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              no_wait,
    input  logic              mreq_n,
    input  logic              iorq_n,
    output logic              wait_n,
    output logic              cyc_slot,
    output logic              vid_strobe,
    output logic [PW-1:0]     phase,
    input  logic [NUM_CH-1:0] ch_req,
    output logic [NUM_CH-1:0] ch_grant,
    output logic [15:0]       wait_count
);
    if (PERIOD < 2 || CPU_PHASE == VID_PHASE || CPU_PHASE < 0 || VID_PHASE < 0 ||
        CPU_PHASE >= PERIOD || VID_PHASE >= PERIOD || NUM_CH < 1 || NUM_CH > 8) begin : g_bad_cfg
        $fatal(1, "cpc_slot_sequencer: illegal parameter combination");
    end
    logic [PW-1:0]     phase_q, phase_d;
    logic [RW-1:0]     rr_q, rr_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              vid_q, vid_d;
    logic              free_phase, cpu_own, found;
    assign phase      = phase_q;
    assign ch_grant   = grant_q;
    assign vid_strobe = vid_q;
    assign cyc_slot   = reset_n && (phase_q == PW'(CPU_PHASE));
    assign wait_n     = !reset_n || cyc_slot || (mreq_n && iorq_n) || no_wait;
    assign free_phase = (phase_q != PW'(CPU_PHASE)) && (phase_q != PW'(VID_PHASE));
    assign cpu_own    = no_wait && (!mreq_n || !iorq_n);
    always_comb begin
        phase_d = phase_q;
        rr_d    = rr_q;
        grant_d = '0;
        vid_d   = 1'b0;
        found   = 1'b0;
        if (ce) begin
            phase_d = (phase_q == PW'(PERIOD - 1)) ? '0 : phase_q + 1'b1;
            vid_d   = (phase_q == PW'(VID_PHASE));
            if (free_phase && !cpu_own) begin
                // k walks the ring from rr_q; the first asserted request wins
                for (int k = 0; k < NUM_CH; k++) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (!found && ch_req[i] && ((int'(rr_q) + k) % NUM_CH == i)) begin
                            grant_d[i] = 1'b1;
                            rr_d       = RW'((i + 1) % NUM_CH);
                            found      = 1'b1;
                        end
                    end
                end
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            vid_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            vid_q   <= vid_d;
        end
    end
`ifdef SLOT_STATS_EN
    logic [15:0] wcnt_q, wcnt_d;
    assign wcnt_d     = (ce && !wait_n && wcnt_q != 16'hFFFF) ? wcnt_q + 16'd1 : wcnt_q;
    assign wait_count = wcnt_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wcnt_q <= '0;
        else          wcnt_q <= wcnt_d;
    end
`else
    assign wait_count = 16'd0;
`endif
endmodule
